serial_adder: RTL and testbench

Bit-serial N-bit adder, the additive counterpart of the team's full subtractor. It accepts two operands and a carry-in through a valid/ready start handshake. It then streams them LSB-first through a single one-bit full adder with a registered carry, one bit per clock, and presents the sum through a valid/ready result handshake. It is used in area-constrained datapaths where one full-adder cell is reused over WIDTH cycles.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_if.sv | 28 ++
 rtl/serial_adder_full_adder.sv | 14 +
 rtl/serial_adder.sv | 101 ++++++++++
 tb/tb_serial_adder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder slice.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Start/result handshake bundle for serial_adder; master drives operands, slave is the adder.
interface serial_adder_if
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             done_valid;
    logic             done_ready;

    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, busy, sum, cout, ovf, done_valid
    );

    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, busy, sum, cout, ovf, done_valid
    );
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell, reused every cycle by serial_adder.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_co
);
    logic w_p;

    assign w_p  = i_a ^ i_b;
    assign o_s  = w_p ^ i_cin;
    assign o_co = (i_a & i_b) | (i_cin & w_p);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands stream LSB-first through one full adder with a
// registered carry; result is offered on a valid/ready handshake.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done_valid;
    logic             r_start_ready;

    logic w_s;
    logic w_co;

    full_adder u_fa (
        .i_a   (r_a_sr[0]),
        .i_b   (r_b_sr[0]),
        .i_cin (r_carry),
        .o_s   (w_s),
        .o_co  (w_co)
    );

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_a_sr        <= '0;
            r_b_sr        <= '0;
            r_sum_sr      <= '0;
            r_carry       <= 1'b0;
            r_cnt         <= '0;
            r_cout        <= 1'b0;
            r_ovf         <= 1'b0;
            r_busy        <= 1'b0;
            r_done_valid  <= 1'b0;
            r_start_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_valid && r_start_ready) begin
                        r_a_sr        <= bus.a;
                        r_b_sr        <= bus.b;
                        r_carry       <= bus.cin;
                        r_cnt         <= '0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + 1'b1;
                    // On the MSB cycle r_carry is the carry into the MSB.
                    if (r_cnt == LAST) begin
                        r_cout       <= w_co;
                        r_ovf        <= r_carry ^ w_co;
                        r_busy       <= 1'b0;
                        r_done_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (r_done_valid && bus.done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = r_start_ready;
    assign bus.busy        = r_busy;
    assign bus.sum         = r_sum_sr;
    assign bus.cout        = r_cout;
    assign bus.ovf         = r_ovf;
    assign bus.done_valid  = r_done_valid;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive).
module tb_serial_adder;
    import serial_arith_pkg::*;

    typedef struct {
        logic [32:0] res;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    exp_t q8[$];
    exp_t q4[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_mode8 = 0;   // 0: always ready, 1: random, 2: held low
    int   rdy_mode4 = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual=timeout/unexpected required=event", name);
    endtask

    // Reference: plain integer arithmetic, signed overflow from the range of the true signed sum.
    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic cin);
        exp_t    e;
        longint  ua = longint'(a);
        longint  ub = longint'(b);
        longint  sa = a[w-1] ? ua - (longint'(1) << w) : ua;
        longint  sb = b[w-1] ? ub - (longint'(1) << w) : ub;
        longint  full = ua + ub + longint'(cin);
        longint  ss = sa + sb + longint'(cin);
        longint  hi = (longint'(1) << (w - 1)) - 1;
        longint  lo = -(longint'(1) << (w - 1));
        e.res = full[32:0];
        e.ovf = (ss > hi) || (ss < lo);
        return e;
    endfunction

    // Consumer-side ready generators.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus8.done_ready = (rdy_mode8 == 0) ? 1'b1 : (rdy_mode8 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus4.done_ready = (rdy_mode4 == 0) ? 1'b1 : (rdy_mode4 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitors: a result is consumed on the edge following a negedge with valid && ready.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n && bus8.done_valid && bus8.done_ready) begin
            if (q8.size() == 0) fail("w8 unexpected result");
            else begin
                e = q8.pop_front();
                check("w8 sum", 64'(bus8.sum), 64'(e.res[7:0]));
                check("w8 cout", 64'(bus8.cout), 64'(e.res[8]));
                check("w8 ovf", 64'(bus8.ovf), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst_n && bus4.done_valid && bus4.done_ready) begin
            if (q4.size() == 0) fail("w4 unexpected result");
            else begin
                e = q4.pop_front();
                check("w4 sum", 64'(bus4.sum), 64'(e.res[3:0]));
                check("w4 cout", 64'(bus4.cout), 64'(e.res[4]));
                check("w4 ovf", 64'(bus4.ovf), 64'(e.ovf));
            end
        end
    end

    task automatic issue8(logic [7:0] a, logic [7:0] b, logic cin, bit push, bit lat);
        int k = 0;
        @(negedge clk);
        while (!bus8.start_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus8.start_ready) begin
            fail("w8 start_ready wait");
            return;
        end
        bus8.start_valid = 1'b1;
        bus8.a = a;
        bus8.b = b;
        bus8.cin = cin;
        @(posedge clk);
        if (push) q8.push_back(model(8, 32'(a), 32'(b), cin));
        #1;
        bus8.start_valid = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.cin = 1'($urandom);
        if (lat) begin
            @(negedge clk);
            check("w8 busy after accept", 64'(bus8.busy), 64'd1);
            check("w8 start_ready after accept", 64'(bus8.start_ready), 64'd0);
            k = 0;
            while (!bus8.done_valid && k < 100) begin
                @(posedge clk);
                k++;
                @(negedge clk);
            end
            check("w8 latency", 64'(k), 64'd8);
        end
    endtask

    task automatic issue4(logic [3:0] a, logic [3:0] b, logic cin);
        int k = 0;
        @(negedge clk);
        while (!bus4.start_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus4.start_ready) begin
            fail("w4 start_ready wait");
            return;
        end
        bus4.start_valid = 1'b1;
        bus4.a = a;
        bus4.b = b;
        bus4.cin = cin;
        @(posedge clk);
        q4.push_back(model(4, 32'(a), 32'(b), cin));
        #1;
        bus4.start_valid = 1'b0;
        bus4.a = 4'($urandom);
        bus4.b = 4'($urandom);
        @(negedge clk);
        k = 0;
        while (!bus4.done_valid && k < 100) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check("w4 latency", 64'(k), 64'd4);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bus8.start_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.done_ready = 1'b1;
        bus4.start_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.done_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst start_ready", 64'(bus8.start_ready), 64'd1);
        check("rst done_valid", 64'(bus8.done_valid), 64'd0);
        check("rst busy", 64'(bus8.busy), 64'd0);
        check("rst sum", 64'(bus8.sum), 64'd0);
        check("rst cout", 64'(bus8.cout), 64'd0);
        check("rst ovf", 64'(bus8.ovf), 64'd0);
        check("rst w4 start_ready", 64'(bus4.start_ready), 64'd1);
        check("rst w4 done_valid", 64'(bus4.done_valid), 64'd0);

        // Directed corner cases
        issue8(8'h5A, 8'h3C, 1'b0, 1'b1, 1'b1);
        issue8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
        issue8(8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);
        issue8(8'h80, 8'h80, 1'b0, 1'b1, 1'b1);
        issue8(8'h7F, 8'h00, 1'b1, 1'b1, 1'b1);

        // Backpressure with ignored start pulses during SHIFT and DONE
        rdy_mode8 = 2;
        @(posedge clk);
        issue8(8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bus8.start_valid = 1'b1;
        bus8.a = 8'hAA;
        bus8.b = 8'h55;
        check("bp start_ready in SHIFT", 64'(bus8.start_ready), 64'd0);
        k = 0;
        while (!bus8.done_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus8.done_valid) fail("bp done_valid wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp done_valid hold", 64'(bus8.done_valid), 64'd1);
            check("bp sum hold", 64'(bus8.sum), 64'h47);
            check("bp cout hold", 64'(bus8.cout), 64'd0);
            check("bp ovf hold", 64'(bus8.ovf), 64'd0);
            check("bp start_ready in DONE", 64'(bus8.start_ready), 64'd0);
        end
        bus8.start_valid = 1'b0;
        rdy_mode8 = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp done_valid dropped", 64'(bus8.done_valid), 64'd0);
        check("bp back to IDLE", 64'(bus8.start_ready), 64'd1);
        check("bp sum kept in IDLE", 64'(bus8.sum), 64'h47);

        // Reset in the middle of SHIFT
        issue8(8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst busy", 64'(bus8.busy), 64'd0);
        check("midrst done_valid", 64'(bus8.done_valid), 64'd0);
        check("midrst start_ready", 64'(bus8.start_ready), 64'd1);
        check("midrst sum", 64'(bus8.sum), 64'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst no result", 64'(bus8.done_valid), 64'd0);
        issue8(8'h01, 8'h01, 1'b0, 1'b1, 1'b1);

        // Random operands with random consumer stalls
        rdy_mode8 = 1;
        for (int i = 0; i < 150; i++)
            issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b1);
        rdy_mode8 = 0;

        // Exhaustive WIDTH=4 with random stalls
        rdy_mode4 = 1;
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    issue4(4'(a), 4'(b), 1'(c));
        rdy_mode4 = 0;

        k = 0;
        while ((q8.size() != 0 || q4.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("w8 queue drained", 64'(q8.size()), 64'd0);
        check("w4 queue drained", 64'(q4.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
